// File: rtl/aes_pkg.sv
// Shared AES loader definitions: key-length encodings, FSM states,
// and the Nk/Nr/key-byte lookups derived from the latched key length.
package aes_pkg;

    typedef enum logic [1:0] {
        KL_128 = 2'd0,
        KL_192 = 2'd1,
        KL_256 = 2'd2,
        KL_BAD = 2'd3
    } key_len_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD_KEY  = 2'd1,
        ST_LOAD_DATA = 2'd2,
        ST_PRESENT   = 2'd3
    } state_e;

    localparam int KEY_BYTES_128 = 16;
    localparam int KEY_BYTES_192 = 24;
    localparam int KEY_BYTES_256 = 32;
    localparam int DATA_BYTES    = 16;

    // Number of 32-bit key words for a key length code.
    function automatic logic [3:0] nk_of(input logic [1:0] kl);
        case (kl)
            KL_192:  nk_of = 4'd6;
            KL_256:  nk_of = 4'd8;
            default: nk_of = 4'd4;
        endcase
    endfunction

    // Number of AES rounds for a key length code.
    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        case (kl)
            KL_192:  nr_of = 4'd12;
            KL_256:  nr_of = 4'd14;
            default: nr_of = 4'd10;
        endcase
    endfunction

    // Index of the final key byte (byte count minus one) so the compare
    // fits the 5-bit byte counter even for 32-byte keys.
    function automatic logic [4:0] key_last_idx(input logic [1:0] kl);
        case (kl)
            KL_192:  key_last_idx = 5'(KEY_BYTES_192 - 1);
            KL_256:  key_last_idx = 5'(KEY_BYTES_256 - 1);
            default: key_last_idx = 5'(KEY_BYTES_128 - 1);
        endcase
    endfunction

endpackage

// File: rtl/aes_block_loader.sv
// Byte-serial loader for an AES core: collects a 16/24/32-byte key and a
// 16-byte data block MSB-first, then presents them with a valid/ready
// handshake. key_hold at the handshake reuses the key for the next block.
//
// Handshakes: a byte moves when in_valid & in_ready are both high at a
// rising clk edge; a block moves when out_valid & out_ready are both high
// at a rising clk edge. abort wins over both in the same cycle.
module aes_block_loader
    import aes_pkg::*;
#(
    parameter int MAX_NK = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            key_len,
    input  logic                  abort,
    input  logic                  in_valid,
    input  logic [7:0]            in_byte,
    output logic                  in_ready,
    input  logic                  key_hold,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [127:0]          out_data,
    output logic [32*MAX_NK-1:0]  out_key,
    output logic [3:0]            out_nk,
    output logic [3:0]            out_nr,
    output logic                  busy,
    output logic                  err,
    output state_e                dbg_state
);

    localparam int KEY_W = 32 * MAX_NK;

    state_e           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [127:0]     data_q, data_d;
    logic [1:0]       klen_q, klen_d;
    logic             err_q, err_d;
    logic [3:0]       nk_q, nr_q;
    logic             in_ready_q, out_valid_q, busy_q;
    logic             byte_acc;

    assign byte_acc = in_valid & in_ready_q;

    // Next-state, counter and shift-in register updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        data_d  = data_q;
        klen_d  = klen_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (key_len == KL_BAD) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_LOAD_KEY;
                        klen_d  = key_len;
                        key_d   = '0;
                        data_d  = '0;
                        cnt_d   = '0;
                    end
                end
            end
            ST_LOAD_KEY: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (byte_acc) begin
                    // Registers were cleared at start, so OR-ing in the
                    // shifted byte places it at the next lower slot.
                    key_d = key_q | ({in_byte, {(KEY_W-8){1'b0}}} >> {cnt_q, 3'b000});
                    if (cnt_q == key_last_idx(klen_q)) begin
                        state_d = ST_LOAD_DATA;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            ST_LOAD_DATA: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (byte_acc) begin
                    data_d = data_q | ({in_byte, 120'd0} >> {cnt_q, 3'b000});
                    if (cnt_q == 5'(DATA_BYTES - 1)) begin
                        state_d = ST_PRESENT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            ST_PRESENT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (out_ready) begin
                    if (key_hold) begin
                        state_d = ST_LOAD_DATA;
                        data_d  = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register with outputs registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            key_q       <= '0;
            data_q      <= '0;
            klen_q      <= KL_128;
            err_q       <= 1'b0;
            nk_q        <= 4'd4;
            nr_q        <= 4'd10;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            data_q      <= data_d;
            klen_q      <= klen_d;
            err_q       <= err_d;
            nk_q        <= nk_of(klen_d);
            nr_q        <= nr_of(klen_d);
            in_ready_q  <= (state_d == ST_LOAD_KEY) || (state_d == ST_LOAD_DATA);
            out_valid_q <= (state_d == ST_PRESENT);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = data_q;
    assign out_key   = key_q;
    assign out_nk    = nk_q;
    assign out_nr    = nr_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed bench for aes_block_loader: table of legal key lengths driven
// through full loads, plus hand sequences for key_hold, illegal key_len,
// abort and mid-load reset.
module tb_aes_block_loader;
    import aes_pkg::*;

    logic           clk;
    logic           rst;
    logic           start;
    logic [1:0]     key_len;
    logic           abort;
    logic           in_valid;
    logic [7:0]     in_byte;
    logic           in_ready;
    logic           key_hold;
    logic           out_valid;
    logic           out_ready;
    logic [127:0]   out_data;
    logic [255:0]   out_key;
    logic [3:0]     out_nk;
    logic [3:0]     out_nr;
    logic           busy;
    logic           err;
    state_e         dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] DATA_A = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] DATA_B = 128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0;

    typedef struct {
        logic [1:0]   key_len;
        int           n_key;
        logic [3:0]   nk;
        logic [3:0]   nr;
        logic [255:0] key;
    } vec_t;

    vec_t vec[3];

    aes_block_loader #(.MAX_NK(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_len   (key_len),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .in_ready  (in_ready),
        .key_hold  (key_hold),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_key   (out_key),
        .out_nk    (out_nk),
        .out_nr    (out_nr),
        .busy      (busy),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " out_valid"}, 256'(out_valid), 256'd0);
        check({tag, " in_ready"},  256'(in_ready),  256'd0);
        check({tag, " busy"},      256'(busy),      256'd0);
        check({tag, " err"},       256'(err),       256'd0);
        check({tag, " out_data"},  256'(out_data),  256'd0);
        check({tag, " out_key"},   out_key,         256'd0);
        check({tag, " out_nk"},    256'(out_nk),    256'd4);
        check({tag, " out_nr"},    256'(out_nr),    256'd10);
    endtask

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic send_byte(input logic [7:0] b);
        int n;
        in_valid = 1'b1;
        in_byte  = b;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_byte timeout: in_ready=%0d required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_start(input logic [1:0] kl);
        start   = 1'b1;
        key_len = kl;
        @(negedge clk);
        start   = 1'b0;
        key_len = 2'd0;
    endtask

    task automatic handshake(input logic hold);
        out_ready = 1'b1;
        key_hold  = hold;
        @(negedge clk);
        out_ready = 1'b0;
        key_hold  = 1'b0;
    endtask

    // Full key+data load for table entry idx, ending in PRESENT after a stall.
    task automatic run_load(input int idx);
        vec_t e;
        e = vec[idx];
        do_start(e.key_len);
        check("start busy",     256'(busy),     256'd1);
        check("start in_ready", 256'(in_ready), 256'd1);
        check("start out_key",  out_key,        256'd0);
        check("start out_data", 256'(out_data), 256'd0);
        check("start out_nk",   256'(out_nk),   256'(e.nk));
        check("start out_nr",   256'(out_nr),   256'(e.nr));
        for (int i = 0; i < e.n_key; i++) send_byte(8'(i));
        check("key done out_key",  out_key,        e.key);
        check("key done in_ready", 256'(in_ready), 256'd1);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check("pre-last out_valid", 256'(out_valid), 256'd0);
            send_byte(8'(i * 17));
        end
        check("present out_valid", 256'(out_valid), 256'd1);
        check("present in_ready",  256'(in_ready),  256'd0);
        check("present out_data",  256'(out_data),  256'(DATA_A));
        check("present out_key",   out_key,         e.key);
        check("present out_nk",    256'(out_nk),    256'(e.nk));
        check("present out_nr",    256'(out_nr),    256'(e.nr));
        // Downstream stalls while stray bytes are offered.
        in_valid = 1'b1;
        in_byte  = 8'h5a;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall out_valid", 256'(out_valid), 256'd1);
            check("stall in_ready",  256'(in_ready),  256'd0);
            check("stall out_data",  256'(out_data),  256'(DATA_A));
            check("stall out_key",   out_key,         e.key);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        vec[0] = '{key_len: 2'd0, n_key: 16, nk: 4'd4, nr: 4'd10,
                   key: 256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000};
        vec[1] = '{key_len: 2'd1, n_key: 24, nk: 4'd6, nr: 4'd12,
                   key: 256'h000102030405060708090a0b0c0d0e0f1011121314151617_0000000000000000};
        vec[2] = '{key_len: 2'd2, n_key: 32, nk: 4'd8, nr: 4'd14,
                   key: 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f};

        rst = 1'b0; start = 1'b0; key_len = 2'd0; abort = 1'b0;
        in_valid = 1'b0; in_byte = 8'h00; key_hold = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b1;
        @(negedge clk);

        // Table: each legal key length, finished with a plain handshake.
        for (int v = 0; v < 3; v++) begin
            run_load(v);
            handshake(1'b0);
            check("release busy",      256'(busy),      256'd0);
            check("release out_valid", 256'(out_valid), 256'd0);
            check("release out_nk",    256'(out_nk),    256'(vec[v].nk));
        end

        // key_hold: second block reuses the AES-128 key.
        run_load(0);
        handshake(1'b1);
        check("hold busy",      256'(busy),      256'd1);
        check("hold in_ready",  256'(in_ready),  256'd1);
        check("hold out_valid", 256'(out_valid), 256'd0);
        check("hold out_data",  256'(out_data),  256'd0);
        check("hold out_key",   out_key,         vec[0].key);
        for (int i = 0; i < 16; i++) send_byte(8'(8'hff - i));
        check("hold2 out_valid", 256'(out_valid), 256'd1);
        check("hold2 out_data",  256'(out_data),  256'(DATA_B));
        check("hold2 out_key",   out_key,         vec[0].key);
        check("hold2 out_nr",    256'(out_nr),    256'd10);
        handshake(1'b0);

        // Illegal key length: one-cycle err, nothing else moves.
        do_start(2'd3);
        check("bad err",      256'(err),      256'd1);
        check("bad busy",     256'(busy),     256'd0);
        check("bad in_ready", 256'(in_ready), 256'd0);
        check("bad out_key",  out_key,        vec[0].key);
        check("bad out_nk",   256'(out_nk),   256'd4);
        @(negedge clk);
        check("bad err drop", 256'(err), 256'd0);

        // Abort after 10 AES-192 key bytes, with a byte offered that cycle.
        do_start(2'd1);
        for (int i = 0; i < 10; i++) send_byte(8'(8'hc0 + i));
        abort    = 1'b1;
        in_valid = 1'b1;
        in_byte  = 8'haa;
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        check("abort busy",     256'(busy),     256'd0);
        check("abort in_ready", 256'(in_ready), 256'd0);
        run_load(1);
        handshake(1'b0);

        // Abort beats an output handshake in the same cycle.
        run_load(2);
        abort     = 1'b1;
        out_ready = 1'b1;
        key_hold  = 1'b1;
        @(negedge clk);
        abort = 1'b0; out_ready = 1'b0; key_hold = 1'b0;
        check("abort present out_valid", 256'(out_valid), 256'd0);
        check("abort present busy",      256'(busy),      256'd0);
        check("abort present in_ready",  256'(in_ready),  256'd0);

        // Start while busy is ignored.
        do_start(2'd0);
        for (int i = 0; i < 4; i++) send_byte(8'(i));
        do_start(2'd2);
        check("busy start out_nk", 256'(out_nk), 256'd4);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;

        // Reset mid LOAD_DATA.
        do_start(2'd0);
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        for (int i = 0; i < 5; i++) send_byte(8'(i * 17));
        rst = 1'b0;
        #1;
        check_reset_values("midreset");
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_byte = 8'(8'h30 + c);
            @(negedge clk);
            check("post reset in_ready", 256'(in_ready), 256'd0);
            check("post reset out_key",  out_key,        256'd0);
        end
        in_valid = 1'b0;
        run_load(0);
        handshake(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
